fwd_hazard_unit: RTL and testbench

- Parametrised next-generation operand forwarding and hazard unit for the in-order RISC-V pipeline (ID/EX/MEM/WB).
- Tracks destination-register metadata of in-flight instructions in its own EX/MEM/WB slot registers.
- Drives per-source forwarding selects for the instruction in EX.
- Detects load-use hazards, inserts one-cycle bubbles, and counts stall cycles.
- Adds over the previous unit: x0 exclusion, newest-producer (MEM) priority, N sources, hold/flush handling, stall counter.

---
 rtl/fwd_hazard_unit_pkg.sv | 25 ++
 rtl/fwd_hazard_unit_src_select.sv | 47 ++++
 rtl/fwd_hazard_unit.sv | 154 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the operand forwarding / load-use hazard unit.
//   - forwarding select encodings driven per EX source operand
//   - control-field struct carried by every pipeline slot (EX/MEM/WB)
package fwd_hazard_unit_pkg;

    localparam int unsigned FWD_SEL_W = 2;

    localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM     = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_WB      = 2'b10;

    // Default architectural register address width (x0..x31).
    localparam int unsigned DEF_REG_W = 5;

    // Per-slot control bits; the register address itself is carried beside
    // this struct because its width follows the REG_W parameter.
    typedef struct packed {
        logic valid;
        logic we;
        logic is_load;
    } slot_ctrl_t;

    localparam int unsigned SLOT_CTRL_W = $bits(slot_ctrl_t);

endpackage : fwd_hazard_unit_pkg

// File: rtl/fwd_hazard_unit_src_select.sv
// Per-source forwarding priority compare for the instruction in EX.
// Ports:
//   ex_valid, rs_used, rs      : EX instruction and one of its source operands
//   mem_eff, mem_is_load, mem_rd : MEM slot effective write / load flag / dest
//   wb_eff, wb_rd              : WB slot effective write / dest
//   fwd_sel_c                  : 00 regfile, 01 MEM, 10 WB (combinational)
module fwd_src_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic                 ex_valid,
    input  logic                 rs_used,
    input  logic [REG_W-1:0]     rs,
    input  logic                 mem_eff,
    input  logic                 mem_is_load,
    input  logic [REG_W-1:0]     mem_rd,
    input  logic                 wb_eff,
    input  logic [REG_W-1:0]     wb_rd,
    output logic [FWD_SEL_W-1:0] fwd_sel_c
);

    logic consider;
    logic mem_hit;
    logic wb_hit;

    // x0 reads are hard-wired zero and never forwarded.
    assign consider = ex_valid && rs_used && (rs != '0);

    // Load data is not available at MEM, so a MEM-slot load is never a
    // forwarding source; the source falls through to the WB compare.
    assign mem_hit = mem_eff && !mem_is_load && (mem_rd == rs);
    assign wb_hit  = wb_eff && (wb_rd == rs);

    // MEM holds the newer producer and therefore wins over WB.
    always_comb begin
        fwd_sel_c = FWD_REGFILE;
        if (consider) begin
            if (mem_hit) begin
                fwd_sel_c = FWD_MEM;
            end else if (wb_hit) begin
                fwd_sel_c = FWD_WB;
            end
        end
    end

endmodule : fwd_src_select

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for an in-order ID/EX/MEM/WB
// pipeline. Tracks destination metadata of in-flight instructions, drives
// per-source forwarding selects for EX, requests one-cycle load-use stalls
// and counts stall cycles (saturating).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_*                : instruction currently in ID
//   hold                : global freeze, all slots keep their values
//   flush               : redirect, kills ID and EX
//   fwd_sel             : 2 bits per EX source (combinational from slots)
//   stall               : load-use stall request (combinational)
//   stall_count         : saturating count of stalled, non-held cycles
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W   = DEF_REG_W,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_W-1:0]     id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic [REG_W-1:0]             id_rd,
    input  logic                         id_we,
    input  logic                         id_is_load,
    input  logic                         hold,
    input  logic                         flush,
    output logic [FWD_SEL_W*NUM_SRC-1:0] fwd_sel,
    output logic                         stall,
    output logic [CNT_W-1:0]             stall_count
);

    // Slot state.
    slot_ctrl_t                 ex_ctrl_q,  ex_ctrl_d;
    logic [REG_W-1:0]           ex_rd_q,    ex_rd_d;
    logic [NUM_SRC*REG_W-1:0]   ex_rs_q,    ex_rs_d;
    logic [NUM_SRC-1:0]         ex_used_q,  ex_used_d;
    slot_ctrl_t                 mem_ctrl_q, mem_ctrl_d;
    logic [REG_W-1:0]           mem_rd_q,   mem_rd_d;
    slot_ctrl_t                 wb_ctrl_q,  wb_ctrl_d;
    logic [REG_W-1:0]           wb_rd_q,    wb_rd_d;
    logic [CNT_W-1:0]           stall_count_q, stall_count_d;

    logic ex_eff;
    logic mem_eff;
    logic wb_eff;
    logic use_match;
    logic stall_c;

    // Effective write: valid, writing, and not targeting x0.
    assign ex_eff  = ex_ctrl_q.valid  && ex_ctrl_q.we  && (ex_rd_q  != '0);
    assign mem_eff = mem_ctrl_q.valid && mem_ctrl_q.we && (mem_rd_q != '0);
    assign wb_eff  = wb_ctrl_q.valid  && wb_ctrl_q.we  && (wb_rd_q  != '0);

    // Forwarding selects, one compare block per EX source operand.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_select #(
            .REG_W(REG_W)
        ) u_src_select (
            .ex_valid    (ex_ctrl_q.valid),
            .rs_used     (ex_used_q[g]),
            .rs          (ex_rs_q[g*REG_W +: REG_W]),
            .mem_eff     (mem_eff),
            .mem_is_load (mem_ctrl_q.is_load),
            .mem_rd      (mem_rd_q),
            .wb_eff      (wb_eff),
            .wb_rd       (wb_rd_q),
            .fwd_sel_c   (fwd_sel[g*FWD_SEL_W +: FWD_SEL_W])
        );
    end

    // Any used ID source reading the load destination currently in EX.
    always_comb begin
        use_match = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (id_rs_used[i] && (id_rs[i*REG_W +: REG_W] == ex_rd_q)) begin
                use_match = 1'b1;
            end
        end
    end

    // A flush kills the consumer, so no stall is needed for it.
    assign stall_c = id_valid && ex_eff && ex_ctrl_q.is_load && use_match && !flush;
    assign stall   = stall_c;

    // Slot advance: hold freezes everything, flush/stall inject an EX bubble.
    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        ex_rs_d    = ex_rs_q;
        ex_used_d  = ex_used_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_rd_d   = mem_rd_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_rd_d    = wb_rd_q;

        if (!hold) begin
            mem_ctrl_d = ex_ctrl_q;
            mem_rd_d   = ex_rd_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_rd_d    = mem_rd_q;
            if (flush || stall_c) begin
                ex_ctrl_d = '0;
                ex_rd_d   = '0;
                ex_rs_d   = '0;
                ex_used_d = '0;
            end else begin
                ex_ctrl_d.valid   = id_valid;
                ex_ctrl_d.we      = id_we;
                ex_ctrl_d.is_load = id_is_load;
                ex_rd_d           = id_rd;
                ex_rs_d           = id_rs;
                ex_used_d         = id_rs_used;
            end
        end
    end

    // Saturating stall-cycle counter; held cycles are not counted.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && !hold && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl_q     <= '0;
            ex_rd_q       <= '0;
            ex_rs_q       <= '0;
            ex_used_q     <= '0;
            mem_ctrl_q    <= '0;
            mem_rd_q      <= '0;
            wb_ctrl_q     <= '0;
            wb_rd_q       <= '0;
            stall_count_q <= '0;
        end else begin
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs_q       <= ex_rs_d;
            ex_used_q     <= ex_used_d;
            mem_ctrl_q    <= mem_ctrl_d;
            mem_rd_q      <= mem_rd_d;
            wb_ctrl_q     <= wb_ctrl_d;
            wb_rd_q       <= wb_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (REG_W=5, NUM_SRC=2, CNT_W=4).
module tb_fwd_hazard_unit;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned CNT_W   = 4;

    logic                     clk;
    logic                     rst;
    logic                     id_valid;
    logic [NUM_SRC*REG_W-1:0] id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [REG_W-1:0]         id_rd;
    logic                     id_we;
    logic                     id_is_load;
    logic                     hold;
    logic                     flush;
    logic [2*NUM_SRC-1:0]     fwd_sel;
    logic                     stall;
    logic [CNT_W-1:0]         stall_count;

    int n_cmp;
    int n_bad;
    logic [CNT_W-1:0] exp_cnt;

    fwd_hazard_unit #(
        .REG_W  (REG_W),
        .NUM_SRC(NUM_SRC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .hold       (hold),
        .flush      (flush),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                            input logic [1:0] used, input logic [4:0] rd,
                            input logic we, input logic ld);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        id_rd      = rd;
        id_we      = we;
        id_is_load = ld;
    endtask

    task automatic drain();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();
        n_cmp++;
        if (fwd_sel !== 4'b0000) begin
            n_bad++; $display("FAIL reset_fwd_sel got=%b exp=%b", fwd_sel, 4'b0000);
        end
        n_cmp++;
        if (stall !== 1'b0 || stall_count !== 4'd0) begin
            n_bad++; $display("FAIL reset_stall got=%b/%0d exp=0/0", stall, stall_count);
        end
        rst = 1'b0;
        exp_cnt = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        drive_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
        tick();
        drive_id(1'b1, 5'd5, 5'd7, 2'b11, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x7
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0001 || stall !== 1'b0) begin
            n_bad++; $display("FAIL b2b_alu got=%b/%b exp=0001/0", fwd_sel, stall);
        end
        drain();
    endtask

    task automatic test_priority();
        // Two writers of x5, then a reader: MEM (newer) wins.
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd5, 5'd3, 2'b11, 5'd10, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0001) begin
            n_bad++; $display("FAIL prio_mem got=%b exp=%b", fwd_sel, 4'b0001);
        end
        drain();
        // Same, but the newer instruction does not write: WB is used.
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 5'd5, 5'd3, 2'b11, 5'd10, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0010) begin
            n_bad++; $display("FAIL prio_wb got=%b exp=%b", fwd_sel, 4'b0010);
        end
        drain();
        // rs_used clear on source 1 even though it matches MEM.
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd3, 5'd12, 2'b01, 5'd13, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0000) begin
            n_bad++; $display("FAIL unused_src got=%b exp=%b", fwd_sel, 4'b0000);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);   // lw x8
        tick();
        drive_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
        #1;
        n_cmp++;
        if (stall !== 1'b1 || stall_count !== 4'd0) begin
            n_bad++; $display("FAIL lu_stall got=%b/%0d exp=1/0", stall, stall_count);
        end
        tick();
        exp_cnt = 4'd1;
        n_cmp++;
        if (stall !== 1'b0 || stall_count !== exp_cnt) begin
            n_bad++; $display("FAIL lu_one_bubble got=%b/%0d exp=0/%0d", stall, stall_count, exp_cnt);
        end
        // Bubble in EX, load in MEM: never a MEM forward.
        n_cmp++;
        if (fwd_sel !== 4'b0000) begin
            n_bad++; $display("FAIL lu_no_mem_load_fwd got=%b exp=%b", fwd_sel, 4'b0000);
        end
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b1010 || stall_count !== exp_cnt) begin
            n_bad++; $display("FAIL lu_wb_fwd got=%b/%0d exp=1010/%0d", fwd_sel, stall_count, exp_cnt);
        end
        drain();
    endtask

    task automatic test_x0();
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd4, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0000) begin
            n_bad++; $display("FAIL x0_fwd got=%b exp=%b", fwd_sel, 4'b0000);
        end
        drain();
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);   // lw x0
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd4, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL x0_load_stall got=%b exp=0", stall);
        end
        drain();
    endtask

    task automatic test_flush_hold();
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL flush_stall got=%b exp=0", stall);
        end
        tick();
        flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (stall_count !== exp_cnt || fwd_sel !== 4'b0000) begin
            n_bad++; $display("FAIL flush_bubble got=%0d/%b exp=%0d/0000", stall_count, fwd_sel, exp_cnt);
        end
        drain();
        // Load-use held for three cycles.
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (stall !== 1'b1 || stall_count !== exp_cnt) begin
                n_bad++; $display("FAIL hold_frozen[%0d] got=%b/%0d exp=1/%0d", k, stall, stall_count, exp_cnt);
            end
            tick();
        end
        hold = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL hold_release_stall got=%b exp=1", stall);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++;
        if (stall !== 1'b0 || stall_count !== exp_cnt) begin
            n_bad++; $display("FAIL hold_count got=%b/%0d exp=0/%0d", stall, stall_count, exp_cnt);
        end
        tick();
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0010) begin
            n_bad++; $display("FAIL hold_wb_fwd got=%b exp=%b", fwd_sel, 4'b0010);
        end
        drain();
    endtask

    task automatic test_saturate_and_reset();
        while (exp_cnt != 4'd15) begin
            drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);
            tick();
            drive_id(1'b1, 5'd3, 5'd8, 2'b10, 5'd9, 1'b1, 1'b0);
            tick();
            exp_cnt = exp_cnt + 4'd1;
            drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
            tick();
        end
        n_cmp++;
        if (stall_count !== 4'd15) begin
            n_bad++; $display("FAIL sat_reach got=%0d exp=15", stall_count);
        end
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL sat_stall got=%b exp=1", stall);
        end
        tick();
        n_cmp++;
        if (stall_count !== 4'd15) begin
            n_bad++; $display("FAIL sat_hold got=%0d exp=15", stall_count);
        end
        drain();
        // Build an active forward + stall, then reset asynchronously.
        drive_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);   // add x5
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);   // lw x8,(x5)
        tick();
        drive_id(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);   // add x9,x8
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0001 || stall !== 1'b1) begin
            n_bad++; $display("FAIL prerst got=%b/%b exp=0001/1", fwd_sel, stall);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0 || stall_count !== 4'd0) begin
            n_bad++; $display("FAIL async_rst got=%b/%b/%0d exp=0000/0/0", fwd_sel, stall, stall_count);
        end
        rst = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (fwd_sel !== 4'b0000 || stall_count !== 4'd0) begin
            n_bad++; $display("FAIL post_rst got=%b/%0d exp=0000/0", fwd_sel, stall_count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_back_to_back();
        test_priority();
        test_load_use();
        test_x0();
        test_flush_hold();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fwd_hazard_unit
